// File: rtl/trit_pack_pkg.sv
// trit_pack_pkg: shared types, radix-3 weights and padding defaults for the trit block packer
package trit_pack_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, PAD, EMIT, DONE} state_e;
  localparam logic [7:0] POW3 [5] = '{8'd1, 8'd3, 8'd9, 8'd27, 8'd81};
  localparam logic [7:0] PAD_DOMAIN_DEF = 8'h06;
  localparam logic [7:0] PAD_FINAL_DEF = 8'h80;
  function automatic int msg_bytes(input int n);
    return (n + 4) / 5;
  endfunction
endpackage

// File: rtl/trit_accum.sv
// trit_accum: reduces each byte mod 3 and packs groups of five trits into one radix-3 byte
//   clk, ovr_rst1 : clock, async active-high reset
//   in_byte, en   : byte to reduce and its transfer strobe
//   flush         : close the current group (with en) or just clear it (without en)
//   pack_byte     : accumulator including the current trit
//   packed_valid  : pack_byte is a finished byte to store this edge
module trit_accum
  import trit_pack_pkg::*;
(
  input  logic       clk,
  input  logic       ovr_rst1,
  input  logic [7:0] in_byte,
  input  logic       en,
  input  logic       flush,
  output logic [7:0] pack_byte,
  output logic       packed_valid
);
  logic [2:0] k_q, k_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] t;
  logic [7:0] term;
  logic       clr;
  assign t = 2'(in_byte % 8'd3);
  assign term = t == 2'd2 ? POW3[k_q] << 1 : t == 2'd1 ? POW3[k_q] : 8'd0;
  assign pack_byte = acc_q + term;
  assign packed_valid = en && (k_q == 3'd4 || flush);
  assign clr = packed_valid || flush;
  assign acc_d = clr ? 8'd0 : en ? pack_byte : acc_q;
  assign k_d = clr ? 3'd0 : en ? k_q + 3'd1 : k_q;
  always_ff @(posedge clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      k_q <= '0;
      acc_q <= '0;
    end else begin
      k_q <= k_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: rtl/trit_block_packer.sv
// trit_block_packer: packs mod-3 trits of a random byte stream into SHA3-padded rate blocks
//   clk, ovr_rst1        : clock, async active-high reset
//   start                : begin a message when idle
//   in_data/valid/ready  : random byte stream in
//   blk_data/valid/last/ready : rate block out to the hash core
//   busy, done, trit_cnt : message status
module trit_block_packer
  import trit_pack_pkg::*;
#(
  parameter int         N_TRITS    = 700,
  parameter int         RATE_BYTES = 136,
  parameter logic [7:0] PAD_DOMAIN = PAD_DOMAIN_DEF,
  parameter logic [7:0] PAD_FINAL  = PAD_FINAL_DEF
) (
  input  logic                             clk,
  input  logic                             ovr_rst1,
  input  logic                             start,
  input  logic [7:0]                       in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [RATE_BYTES*8-1:0]          blk_data,
  output logic                             blk_valid,
  output logic                             blk_last,
  input  logic                             blk_ready,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(N_TRITS+1)-1:0]     trit_cnt
);
  localparam int CW = $clog2(N_TRITS + 1);
  localparam int IW = $clog2(RATE_BYTES + 1);
  localparam int RB = RATE_BYTES * 8;
  state_e          state_q, state_d;
  logic [RB-1:0]   buf_q, buf_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            xfer, last_trit, full, has_room, msg_end, pv;
  logic [7:0]      pack_byte;
  assign xfer = state_q == COLLECT && in_valid;
  assign last_trit = xfer && cnt_q == CW'(N_TRITS - 1);
  assign full = pv && idx_q == IW'(RATE_BYTES - 1);
  assign has_room = idx_q != IW'(RATE_BYTES);
  assign msg_end = cnt_q == CW'(N_TRITS);
  trit_accum u_accum (
    .clk          (clk),
    .ovr_rst1     (ovr_rst1),
    .in_byte      (in_data),
    .en           (xfer),
    .flush        (last_trit || (state_q == IDLE && start)),
    .pack_byte    (pack_byte),
    .packed_valid (pv)
  );
  always_comb begin
    state_d = state_q;
    buf_d = buf_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    last_d = last_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = COLLECT;
        buf_d = '0;
        idx_d = '0;
        cnt_d = '0;
        last_d = 1'b0;
      end
      COLLECT: if (xfer) begin
        cnt_d = cnt_q + CW'(1);
        if (pv) begin
          for (int i = 0; i < RATE_BYTES; i++)
            if (idx_q == IW'(i)) buf_d[8*i +: 8] = pack_byte;
          idx_d = idx_q + IW'(1);
        end
        state_d = last_trit ? PAD : full ? EMIT : COLLECT;
        last_d = 1'b0;
      end
      // A message that fills its block exactly emits that block unpadded first;
      // the return trip through PAD with an empty buffer builds the pad-only block.
      PAD: begin
        state_d = EMIT;
        last_d = has_room;
        if (has_room) begin
          for (int i = 0; i < RATE_BYTES; i++)
            if (idx_q == IW'(i)) buf_d[8*i +: 8] = buf_q[8*i +: 8] ^ PAD_DOMAIN;
          buf_d[RB-1 -: 8] = buf_d[RB-1 -: 8] ^ PAD_FINAL;
        end
      end
      EMIT: if (blk_ready) begin
        buf_d = '0;
        idx_d = '0;
        state_d = last_q ? DONE : msg_end ? PAD : COLLECT;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge ovr_rst1) begin
    if (ovr_rst1) begin
      state_q <= IDLE;
      buf_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
    end
  end
  assign in_ready = state_q == COLLECT;
  assign blk_valid = state_q == EMIT;
  assign blk_last = blk_valid && last_q;
  assign blk_data = blk_valid ? buf_q : '0;
  assign busy = state_q != IDLE && state_q != DONE;
  assign done = state_q == DONE;
  assign trit_cnt = cnt_q;
endmodule

// File: tb/tb_trit_block_packer.sv
// tb_trit_block_packer: scoreboard bench running four packer configurations side by side
module tb_trit_block_packer;
  import trit_pack_pkg::*;
  localparam int R = 4;
  localparam int RB = R * 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int fin = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  genvar g;
  for (g = 0; g < 4; g++) begin : c
    localparam int N = (g == 0) ? 10 : (g == 1) ? 7 : (g == 2) ? 15 : 20;
    localparam int CW = $clog2(N + 1);
    logic rst = 1'b1, start = 1'b0, in_valid = 1'b0, blk_ready = 1'b0;
    logic in_ready, blk_valid, blk_last, busy, done;
    logic [7:0] in_data = 8'd0;
    logic [RB-1:0] blk_data;
    logic [CW-1:0] trit_cnt;
    logic [7:0] msg[$];
    logic [RB-1:0] exp_d[$];
    logic exp_l[$];
    int bp_mode = 0;
    int done_cnt = 0;
    logic hold = 1'b0;
    logic [RB-1:0] held;

    trit_block_packer #(.N_TRITS(N), .RATE_BYTES(R)) dut (
      .clk(clk), .ovr_rst1(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
      .blk_ready(blk_ready), .busy(busy), .done(done), .trit_cnt(trit_cnt)
    );

    always begin
      @(posedge clk);
      #1;
      blk_ready = bp_mode == 0 ? 1'($urandom_range(1)) : bp_mode == 2;
    end

    always @(negedge clk) begin
      if (rst) hold = 1'b0;
      else begin
        if (blk_valid && blk_ready) begin
          if (exp_d.size() == 0) chk("blk_extra", blk_valid, 0);
          else begin
            chk("blk_data", blk_data, exp_d.pop_front());
            chk("blk_last", blk_last, exp_l.pop_front());
          end
        end
        if (hold) begin
          chk("hold_valid", blk_valid, 1);
          chk("hold_data", blk_data, held);
          chk("hold_in_ready", in_ready, 0);
        end
        hold = blk_valid && !blk_ready;
        held = blk_data;
        if (done) begin
          done_cnt++;
          chk("done_pending_blocks", exp_d.size(), 0);
          chk("done_trit_cnt", trit_cnt, N);
          chk("done_busy", busy, 0);
        end
      end
    end

    task automatic push(input logic [RB-1:0] d, input logic l);
      exp_d.push_back(d);
      exp_l.push_back(l);
    endtask

    task automatic expect_msg();
      int nb, nblk, s, p;
      logic [7:0] all[$];
      logic [RB-1:0] d;
      nb = msg_bytes(N);
      nblk = nb / R + 1;
      for (int j = 0; j < nblk * R; j++) all.push_back(8'd0);
      for (int j = 0; j < nb; j++) begin
        s = 0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
          if (5 * j + i < N) s += (int'(msg[5*j+i]) % 3) * p;
          p *= 3;
        end
        all[j] = 8'(s);
      end
      all[nb] ^= PAD_DOMAIN_DEF;
      all[nblk*R-1] ^= PAD_FINAL_DEF;
      for (int b = 0; b < nblk; b++) begin
        d = '0;
        for (int i = 0; i < R; i++) d[8*i +: 8] = all[b*R+i];
        push(d, b == nblk - 1);
      end
    endtask

    task automatic dir_msg();
      msg.delete();
      if (g == 0) begin
        msg = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        push(32'h8006C4C4, 1'b1);
      end else if (g == 1) begin
        repeat (N) msg.push_back(8'd254);
        push(32'h800608F2, 1'b1);
      end else if (g == 2) begin
        repeat (N) msg.push_back(8'd0);
        push(32'h86000000, 1'b1);
      end else begin
        repeat (N) msg.push_back(8'd3);
        push(32'h00000000, 1'b0);
        push(32'h80000006, 1'b1);
      end
    endtask

    task automatic feed(input int n);
      logic ok;
      int w;
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(2) == 0) begin
          in_valid = 1'b0;
          in_data = 8'($urandom);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b1;
        in_data = msg[i];
        start = i == 2;
        w = 0;
        do begin
          @(negedge clk);
          ok = in_ready;
          @(posedge clk);
          #1;
          start = 1'b0;
          w++;
        end while (!ok && w < 500);
        if (!ok) chk("feed_timeout", in_ready, 1);
      end
      in_valid = 1'b0;
    endtask

    task automatic run_msg();
      int prev, w;
      prev = done_cnt;
      w = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("trit_cnt_cleared", trit_cnt, 0);
      feed(N);
      while (done_cnt == prev && w < 3000) begin
        @(posedge clk);
        w++;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt, prev + 1);
      chk("idle_busy", busy, 0);
    endtask

    task automatic bp_seq();
      logic [RB-1:0] d0;
      int w;
      w = 0;
      bp_mode = 1;
      while (!blk_valid && w < 2000) begin
        @(negedge clk);
        w++;
      end
      chk("bp_valid_seen", blk_valid, 1);
      d0 = blk_data;
      repeat (10) begin
        @(negedge clk);
        chk("bp_hold_valid", blk_valid, 1);
        chk("bp_hold_data", blk_data, d0);
        chk("bp_in_ready", in_ready, 0);
      end
      @(posedge clk);
      bp_mode = 2;
      @(negedge clk);
      chk("bp_hs_valid", blk_valid, 1);
      @(posedge clk);
      #2;
      chk("bp_after_hs", blk_valid, 0);
      bp_mode = 0;
    endtask

    task automatic chk_zero(input string s);
      chk({s, "_in_ready"}, in_ready, 0);
      chk({s, "_blk_valid"}, blk_valid, 0);
      chk({s, "_blk_last"}, blk_last, 0);
      chk({s, "_busy"}, busy, 0);
      chk({s, "_done"}, done, 0);
      chk({s, "_blk_data"}, blk_data, 0);
      chk({s, "_trit_cnt"}, trit_cnt, 0);
    endtask

    task automatic rst_test();
      msg.delete();
      repeat (N) msg.push_back(8'($urandom));
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      feed(6);
      chk("pre_rst_trit_cnt", trit_cnt, 6);
      #2 rst = 1'b1;
      #1 chk_zero("mid_rst");
      @(posedge clk);
      #1 rst = 1'b0;
    endtask

    initial begin
      #3 chk_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      dir_msg();
      fork
        run_msg();
        bp_seq();
      join
      rst_test();
      dir_msg();
      fork
        run_msg();
        bp_seq();
      join
      repeat (4) begin
        msg.delete();
        repeat (N) msg.push_back(8'($urandom_range(255)));
        expect_msg();
        run_msg();
      end
      fin++;
    end
  end

  initial begin
    fork
      wait (fin == 4);
      #500000;
    join_any
    if (fin != 4) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d of 4 configurations finished", fin);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/trit_block_packer.md
Name: trit_block_packer

Overview:
- Parametrised successor to the encapsulation sampler front end.
- Takes a stream of random bytes over a valid/ready handshake and reduces each byte mod 3 to one trit.
- Packs 5 trits per byte in radix 3 and assembles SHA3-rate blocks.
- Applies SHA3 padding to the final block and hands each block to the hash core over a valid/ready handshake. The FSM replaces free-running counter sequencing.

Parameters:
- N_TRITS, 700, total trits sampled per message (>=1).
- RATE_BYTES, 136, hash rate in bytes; 136 = SHA3-256 (>=2).
- PAD_DOMAIN, 8'h06, domain-separation byte XORed after the message.
- PAD_FINAL, 8'h80, byte XORed into the last rate byte.

Ports:
- clk  in  1  clock, rising edge
- ovr_rst1  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begins a message when idle
- in_data  in  8  random byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- blk_data  out  RATE_BYTES*8  block; byte i = blk_data[8i+7:8i]
- blk_valid  out  1  block valid
- blk_last  out  1  qualifies blk_valid; final padded block
- blk_ready  in  1  hash core accepts block
- busy  out  1  high from start accept to done
- done  out  1  one-cycle pulse after the last block is accepted
- trit_cnt  out  $clog2(N_TRITS+1)  trits consumed so far

Behaviour:
- Reset (async): FSM=IDLE; buffer, accumulator and counters cleared. in_ready, blk_valid, blk_last, busy, done = 0; blk_data = 0.
- States: IDLE, COLLECT, PAD, EMIT, DONE.
- IDLE:
  - start -> COLLECT. busy=1 from the next cycle; trit_cnt, byte index and group count cleared.
  - start while busy: ignored.
- COLLECT:
  - in_ready=1. A transfer occurs when in_valid & in_ready.
  - Per transfer: t = in_data mod 3 (0..2); acc += t*3^k, with k = 0..4 the position in the current group; trit_cnt++.
  - When k=4, or on trit N_TRITS: acc is written to buffer[byte_idx] at that edge; byte_idx++; acc and k cleared.
  - Packed byte max 242; a final partial group has its missing high trits = 0.
  - byte_idx reaches RATE_BYTES (message not finished) -> EMIT, blk_last=0.
  - Last trit accepted -> PAD.
  - Transfer count per message is exactly N_TRITS; in_ready=0 outside COLLECT.
- PAD (1 cycle):
  - If byte_idx < RATE_BYTES: buffer[byte_idx] ^= PAD_DOMAIN and buffer[RATE_BYTES-1] ^= PAD_FINAL. When byte_idx = RATE_BYTES-1 both land on one byte (0x86). Then -> EMIT with blk_last=1.
  - If byte_idx = RATE_BYTES (message fills the block exactly): EMIT the full block with blk_last=0, then clear the buffer. The next block is pad-only: byte0=PAD_DOMAIN, last byte=PAD_FINAL, emitted with blk_last=1.
- EMIT:
  - blk_valid=1; blk_data and blk_last held stable until blk_ready.
  - On handshake: buffer cleared, byte_idx=0. Not last -> COLLECT (or the pad-only block per PAD). Last -> DONE.
  - blk_ready may be high before blk_valid; no combinational path from blk_ready to in_ready.
- DONE: done=1 for one cycle; busy=0 -> IDLE. A start in the DONE cycle is ignored.
- Latency:
  - Fifth trit accepted at edge n -> byte visible in the buffer at n.
  - Block-filling byte at edge n -> blk_valid=1 in cycle n+1.
  - Final trit at edge n -> PAD in cycle n+1, blk_valid=1 in cycle n+2.
- Block count per message = floor(ceil(N_TRITS/5)/RATE_BYTES)+1.
- Reset mid-operation: all state is discarded immediately. No partial block is emitted and no done pulse is generated.

Decomposition:
- Package trit_pack_pkg:
  - state enum (IDLE, COLLECT, PAD, EMIT, DONE);
  - pow3 table {1,3,9,27,81};
  - PAD_DOMAIN/PAD_FINAL defaults;
  - function msg_bytes(N) = ceil(N/5).
- Sub-module trit_accum: byte mod 3 plus radix-3 group accumulator. Ports: clk, ovr_rst1, in_byte, en, flush, packed, packed_valid.

Test Plan:
- N_TRITS=10, RATE_BYTES=4; inputs 1,2,0,1,2,4,5,6,7,8 -> one block, blk_data=32'h8006C4C4, blk_last=1, done pulse, trit_cnt=10.
- N_TRITS=7, RATE_BYTES=4; seven inputs of 8'hFF-1 (254, mod3=2) -> bytes F2,08; blk_data=32'h800608F2.
- N_TRITS=15, RATE_BYTES=4; inputs 0,...,0 (15 zeros) -> blk_data=32'h86000000, single block, blk_last=1.
- N_TRITS=20, RATE_BYTES=4, all inputs 3 (mod3=0):
  - block 1 = 32'h00000000, blk_last=0;
  - block 2 = 32'h80000006, blk_last=1.
- Backpressure: hold blk_ready=0 for 10 cycles during EMIT -> blk_valid=1, blk_data stable, in_ready=0 throughout; the handshake completes on the first blk_ready=1 cycle. Toggling in_valid in COLLECT must not drop or duplicate trits.
- Reset mid-COLLECT after 6 trits: assert ovr_rst1 -> all outputs 0 immediately. A new start plus 10 inputs gives the same result as scenario 1.
